// File: rtl/otter_mem_arbiter.sv
// rtl/otter_mem_arbiter.sv - shares one word-wide memory port between I-cache refill and D-cache miss service
// Optional OTTER_ARB_RR_EN selects round-robin arbitration; default build gives the D-cache fixed priority.
module otter_mem_arbiter #(
  parameter int IC_WORDS = 8,
  parameter int DC_WORDS = 4,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [31:0]       ic_rdata,
  output logic              ic_rvalid,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_wb,
  input  logic [ADDR_W-1:0] dc_wb_addr,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [31:0]       dc_wdata,
  output logic              dc_wready,
  output logic [31:0]       dc_rdata,
  output logic              dc_rvalid,
  output logic              dc_done,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic              m_ack,
  input  logic [31:0]       m_rdata,
  output logic              stall
);

  localparam int MAX_WORDS = (IC_WORDS > DC_WORDS) ? IC_WORDS : DC_WORDS;
  localparam int CNT_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int IC_OFF    = $clog2(IC_WORDS) + 2;
  localparam int DC_OFF    = $clog2(DC_WORDS) + 2;

  localparam logic [CNT_W-1:0]  IC_LAST = CNT_W'(IC_WORDS - 1);
  localparam logic [CNT_W-1:0]  DC_LAST = CNT_W'(DC_WORDS - 1);
  localparam logic [ADDR_W-1:0] IC_MASK = ~((ADDR_W'(1) << IC_OFF) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] DC_MASK = ~((ADDR_W'(1) << DC_OFF) - ADDR_W'(1));

  typedef enum logic [2:0] {
    IDLE,
    IC_RD,
    DC_WB,
    DC_RD,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] miss_addr;
  logic              owner_dc;
  logic [ADDR_W-1:0] beat_addr;

  logic grant;
  logic dc_pick;
  logic beat_ack;
  logic last_beat;

`ifdef OTTER_ARB_RR_EN
  // Remembers who won the previous grant so a simultaneous request goes to the other side.
  logic last_dc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dc <= 1'b0;
    end else if (grant) begin
      last_dc <= dc_pick;
    end
  end

  assign dc_pick = dc_req & (~ic_req | ~last_dc);
`else
  assign dc_pick = dc_req;
`endif

  assign beat_addr = base_addr + (ADDR_W'(cnt) << 2);
  assign stall     = (state != IDLE) | ic_req | dc_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    beat_ack  = 1'b0;
    last_beat = 1'b0;
    m_req     = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    dc_wready = 1'b0;
    ic_done   = 1'b0;
    dc_done   = 1'b0;
    case (state)
      IDLE: begin
        if (ic_req | dc_req) begin
          grant = 1'b1;
          if (dc_pick) begin
            state_nxt = dc_wb ? DC_WB : DC_RD;
          end else begin
            state_nxt = IC_RD;
          end
        end
      end
      IC_RD: begin
        m_req     = 1'b1;
        m_addr    = beat_addr;
        beat_ack  = m_ack;
        last_beat = (cnt == IC_LAST);
        if (m_ack && last_beat) begin
          state_nxt = DONE;
        end
      end
      DC_WB: begin
        m_req     = 1'b1;
        m_we      = 1'b1;
        m_addr    = beat_addr;
        m_wdata   = dc_wdata;
        dc_wready = m_ack;
        beat_ack  = m_ack;
        last_beat = (cnt == DC_LAST);
        if (m_ack && last_beat) begin
          state_nxt = DC_RD;
        end
      end
      DC_RD: begin
        m_req     = 1'b1;
        m_addr    = beat_addr;
        beat_ack  = m_ack;
        last_beat = (cnt == DC_LAST);
        if (m_ack && last_beat) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        ic_done   = ~owner_dc;
        dc_done   = owner_dc;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Line bookkeeping and registered read return; read data lands one cycle after each ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      base_addr <= '0;
      miss_addr <= '0;
      owner_dc  <= 1'b0;
      ic_rdata  <= '0;
      ic_rvalid <= 1'b0;
      dc_rdata  <= '0;
      dc_rvalid <= 1'b0;
    end else begin
      ic_rvalid <= 1'b0;
      dc_rvalid <= 1'b0;
      if (grant) begin
        cnt      <= '0;
        owner_dc <= dc_pick;
        if (dc_pick) begin
          base_addr <= dc_wb ? (dc_wb_addr & DC_MASK) : (dc_addr & DC_MASK);
          miss_addr <= dc_addr & DC_MASK;
        end else begin
          base_addr <= ic_addr & IC_MASK;
        end
      end
      if (beat_ack) begin
        cnt <= last_beat ? '0 : cnt + CNT_W'(1);
        if (state == DC_WB && last_beat) begin
          base_addr <= miss_addr;
        end
        if (state == IC_RD) begin
          ic_rdata  <= m_rdata;
          ic_rvalid <= 1'b1;
        end
        if (state == DC_RD) begin
          dc_rdata  <= m_rdata;
          dc_rvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// tb/tb_otter_mem_arbiter.sv - bench for otter_mem_arbiter: line-level beat model plus directed scenarios
`timescale 1ns/1ps
module tb_otter_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ic_req = 1'b0;
  logic [31:0] ic_addr = '0;
  logic [31:0] ic_rdata;
  logic        ic_rvalid;
  logic        ic_done;
  logic        dc_req = 1'b0;
  logic        dc_wb = 1'b0;
  logic [31:0] dc_wb_addr = '0;
  logic [31:0] dc_addr = '0;
  logic [31:0] dc_wdata = '0;
  logic        dc_wready;
  logic [31:0] dc_rdata;
  logic        dc_rvalid;
  logic        dc_done;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata;
  logic        stall;

  always #5 clk = ~clk;

  otter_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid), .ic_done(ic_done),
    .dc_req(dc_req), .dc_wb(dc_wb), .dc_wb_addr(dc_wb_addr), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wready(dc_wready), .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_done(dc_done),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata),
    .stall(stall)
  );

  // Memory returns a word derived from the address so every beat is distinguishable.
  logic [31:0] rd_base = '0;
  assign m_rdata = rd_base + ((m_addr >> 2) & 32'h7);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
    logic        own_dc;
    logic        last;
  } beat_t;

  beat_t       beats[$];
  beat_t       b;
  logic [31:0] wb_data [4];
  bit          rv_pend = 0;
  bit          rv_dc = 0;
  bit          rv_last = 0;
  logic [31:0] rv_data = '0;
  bit          mreq_e;
  bit          busy;
  bit          gdc;
`ifdef OTTER_ARB_RR_EN
  bit          m_last_dc = 0;
`endif

  bit          wr_adv = 0;
  int          wb_idx = 0;
  int          cyc = 0;
  bit          ack_every2 = 0;
  int          ack_hold = 0;
  bit          stall_arm = 0;
  logic [31:0] stall_addr = '0;

  int          ncyc = 0;
  int          n_ic_rv = 0, n_dc_rv = 0, n_ic_done = 0, n_dc_done = 0;
  int          n_wready = 0, n_done_rv = 0, n_wait = 0;
  int          last_dc_done_cyc = 0, rise_gap = 0;
  logic [31:0] last_ic_data = '0, last_dc_data = '0;
  bit          prev_mreq = 0;
  logic [31:0] grant_log[$];

  task automatic push_beat(input logic [31:0] a, input logic we, input logic [31:0] wd,
                           input logic own, input logic last);
    beat_t nb;
    nb.addr   = a;
    nb.we     = we;
    nb.data   = we ? wd : rd_base + ((a >> 2) & 32'h7);
    nb.own_dc = own;
    nb.last   = last;
    beats.push_back(nb);
  endtask

  // Model: a granted line becomes a list of expected beats; each acked read returns one cycle later.
  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      beats.delete();
      rv_pend   = 0;
      wr_adv    = 0;
      prev_mreq = 0;
`ifdef OTTER_ARB_RR_EN
      m_last_dc = 0;
`endif
    end else begin
      mreq_e = beats.size() > 0;
      busy   = mreq_e || rv_pend;
      chk("m_req", m_req, mreq_e);
      if (mreq_e) begin
        chk("m_addr", m_addr, beats[0].addr);
        chk("m_we", m_we, beats[0].we);
        if (beats[0].we) chk("m_wdata", m_wdata, beats[0].data);
        chk("dc_wready", dc_wready, beats[0].we & m_ack);
      end else begin
        chk("dc_wready_idle", dc_wready, 0);
      end
      chk("ic_rvalid", ic_rvalid, rv_pend & !rv_dc);
      chk("dc_rvalid", dc_rvalid, rv_pend & rv_dc);
      if (rv_pend && rv_dc) chk("dc_rdata", dc_rdata, rv_data);
      if (rv_pend && !rv_dc) chk("ic_rdata", ic_rdata, rv_data);
      chk("ic_done", ic_done, rv_pend & rv_last & !rv_dc);
      chk("dc_done", dc_done, rv_pend & rv_last & rv_dc);
      chk("stall", stall, busy | ic_req | dc_req);

      if (ic_rvalid) begin n_ic_rv++; last_ic_data = ic_rdata; end
      if (dc_rvalid) begin n_dc_rv++; last_dc_data = dc_rdata; end
      if (ic_done) n_ic_done++;
      if (dc_done) begin n_dc_done++; last_dc_done_cyc = ncyc; end
      if ((ic_done && ic_rvalid) || (dc_done && dc_rvalid)) n_done_rv++;
      if (dc_wready) n_wready++;
      if (m_req && !m_ack) n_wait++;
      if (m_req && !prev_mreq) begin
        grant_log.push_back(m_addr);
        rise_gap = ncyc - last_dc_done_cyc;
      end
      prev_mreq = m_req;
      wr_adv    = dc_wready;

      if (mreq_e && m_ack) begin
        b       = beats.pop_front();
        rv_pend = !b.we;
        rv_dc   = b.own_dc;
        rv_data = b.data;
        rv_last = b.last;
      end else begin
        rv_pend = 0;
        if (!busy && (ic_req || dc_req)) begin
`ifdef OTTER_ARB_RR_EN
          gdc = dc_req && (!ic_req || !m_last_dc);
          m_last_dc = gdc;
`else
          gdc = dc_req;
`endif
          if (gdc) begin
            if (dc_wb)
              for (int k = 0; k < 4; k++)
                push_beat((dc_wb_addr & ~32'hF) + 32'(4 * k), 1'b1, wb_data[k], 1'b1, 1'b0);
            for (int k = 0; k < 4; k++)
              push_beat((dc_addr & ~32'hF) + 32'(4 * k), 1'b0, '0, 1'b1, k == 3);
          end else begin
            for (int k = 0; k < 8; k++)
              push_beat((ic_addr & ~32'h1F) + 32'(4 * k), 1'b0, '0, 1'b0, k == 7);
          end
        end
      end
    end
  end

  // Memory acknowledge and writeback-data source.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (wr_adv) wb_idx++;
    if (ack_hold > 0) begin
      m_ack = 1'b0;
      ack_hold--;
    end else if (stall_arm && m_req && !m_we && m_addr == stall_addr) begin
      m_ack     = 1'b0;
      ack_hold  = 9;
      stall_arm = 0;
    end else begin
      m_ack = ack_every2 ? cyc[0] : 1'b1;
    end
    dc_wdata = wb_data[wb_idx & 3];
  end

  task automatic wait_done(input bit want_dc, output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (want_dc ? dc_done : ic_done) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic run_ic(input logic [31:0] a);
    bit ok;
    @(posedge clk);
    #1;
    ic_addr = a;
    ic_req  = 1'b1;
    wait_done(1'b0, ok);
    chk("ic_done_seen", ok, 1);
    @(posedge clk);
    #1;
    ic_req = 1'b0;
  endtask

  task automatic run_dc(input bit wb, input logic [31:0] wba, input logic [31:0] a, input bit keep);
    bit ok;
    if (!dc_req) begin
      @(posedge clk);
      #1;
    end
    dc_wb      = wb;
    dc_wb_addr = wba;
    dc_addr    = a;
    wb_idx     = 0;
    dc_req     = 1'b1;
    wait_done(1'b1, ok);
    chk("dc_done_seen", ok, 1);
    @(posedge clk);
    #1;
    if (!keep) dc_req = 1'b0;
  endtask

  initial begin
    bit ok;
    int s_ic_rv, s_dc_rv, s_ic_done, s_dc_done, s_wready, s_done_rv, s_wait;
    for (int k = 0; k < 4; k++) wb_data[k] = 32'hD00D_0000 + 32'(k * 32'h111);

    // Power-on reset: every output low.
    repeat (3) @(negedge clk);
    chk("rst_m_req", m_req, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_ic_rvalid", ic_rvalid, 0);
    chk("rst_dc_rvalid", dc_rvalid, 0);
    chk("rst_ic_done", ic_done, 0);
    chk("rst_dc_done", dc_done, 0);
    chk("rst_dc_wready", dc_wready, 0);
    chk("rst_ic_rdata", ic_rdata, 0);
    chk("rst_dc_rdata", dc_rdata, 0);
    chk("rst_stall", stall, 0);
    #2 rst_n = 1'b1;

    // Reset during IC refill beat 3 aborts the line.
    s_ic_done = n_ic_done;
    @(posedge clk);
    #1;
    ic_addr = 32'h0000_0040;
    ic_req  = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_req && m_addr == 32'h4C) begin
        ok = 1;
        break;
      end
    end
    chk("rst_mid_beat3_reached", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_m_req", m_req, 0);
    chk("rst_mid_ic_done", ic_done, 0);
    chk("rst_mid_ic_rvalid", ic_rvalid, 0);
    chk("rst_mid_stall_req", stall, 1);
    ic_req = 1'b0;
    #1;
    chk("rst_mid_stall_noreq", stall, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mid_no_done", n_ic_done - s_ic_done, 0);
    chk("rst_mid_idle_m_req", m_req, 0);

    // Simultaneous requests straight after reset: D-cache first in both arbitration modes.
    rd_base = 32'h50;
    grant_log.delete();
    fork
      run_dc(1'b0, 32'h0, 32'h0000_3010, 1'b0);
      run_ic(32'h0000_1104);
    join
    chk("simA_grants", grant_log.size(), 2);
    chk("simA_first", grant_log[0], 32'h3010);
    chk("simA_second", grant_log[1], 32'h1100);

    // I-cache refill, ack every second cycle.
    ack_every2 = 1;
    rd_base = 32'hA0;
    s_ic_rv = n_ic_rv; s_ic_done = n_ic_done; s_done_rv = n_done_rv;
    grant_log.delete();
    run_ic(32'h0000_1234);
    ack_every2 = 0;
    chk("ic_first_addr", grant_log[0], 32'h1220);
    chk("ic_rvalid_count", n_ic_rv - s_ic_rv, 8);
    chk("ic_last_data", last_ic_data, 32'hA7);
    chk("ic_done_count", n_ic_done - s_ic_done, 1);
    chk("ic_done_with_rvalid", n_done_rv - s_done_rv, 1);

    // D-cache writeback then refill.
    rd_base = 32'hB0;
    s_dc_rv = n_dc_rv; s_dc_done = n_dc_done; s_wready = n_wready;
    grant_log.delete();
    run_dc(1'b1, 32'h0000_2008, 32'h0000_3004, 1'b0);
    chk("dcwb_grants", grant_log.size(), 1);
    chk("dcwb_first_addr", grant_log[0], 32'h2000);
    chk("dcwb_wready_count", n_wready - s_wready, 4);
    chk("dcwb_rvalid_count", n_dc_rv - s_dc_rv, 4);
    chk("dcwb_last_data", last_dc_data, 32'hB3);
    chk("dcwb_done_count", n_dc_done - s_dc_done, 1);

    // Simultaneous requests after a D-cache grant.
    grant_log.delete();
    fork
      run_dc(1'b0, 32'h0, 32'h0000_3010, 1'b0);
      run_ic(32'h0000_1104);
    join
    chk("simB_grants", grant_log.size(), 2);
`ifdef OTTER_ARB_RR_EN
    chk("simB_first", grant_log[0], 32'h1100);
    chk("simB_second", grant_log[1], 32'h3010);
`else
    chk("simB_first", grant_log[0], 32'h3010);
    chk("simB_second", grant_log[1], 32'h1100);
`endif

    // Memory stalls 10 cycles on D-cache read beat 1.
    rd_base = 32'hB0;
    stall_addr = 32'h0000_3004;
    stall_arm = 1;
    s_dc_rv = n_dc_rv; s_wait = n_wait;
    run_dc(1'b0, 32'h0, 32'h0000_3008, 1'b0);
    chk("stall_wait_cycles", n_wait - s_wait, 10);
    chk("stall_rvalid_count", n_dc_rv - s_dc_rv, 4);
    chk("stall_last_data", last_dc_data, 32'hB3);

    // Back-to-back D-cache requests: one idle cycle between DONE and the next beat.
    s_dc_done = n_dc_done;
    run_dc(1'b0, 32'h0, 32'h0000_3000, 1'b1);
    run_dc(1'b0, 32'h0, 32'h0000_3000, 1'b0);
    chk("b2b_gap", rise_gap, 2);
    chk("b2b_done_count", n_dc_done - s_dc_done, 2);

    repeat (3) @(negedge clk);
    chk("end_m_req", m_req, 0);
    chk("end_stall", stall, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
